// File: rtl/dilithium_pkg.sv
// -----------------------------------------------------------------------------
// dilithium_pkg
// Shared constants and helpers for the Dilithium matrix-expansion datapath.
//   N, Q            : polynomial length and modulus
//   K_*/L_*         : matrix dimensions for each security level
//   ST_*            : 3-bit state encoding of the matrix_expand_stream sequencer
//   pack_nonce()    : builds the poly_uniform nonce {row, col}
// -----------------------------------------------------------------------------
package dilithium_pkg;

    localparam int N = 256;
    localparam int Q = 8380417;

    localparam int K_D2 = 4;
    localparam int L_D2 = 4;
    localparam int K_D3 = 6;
    localparam int L_D3 = 5;
    localparam int K_D5 = 8;
    localparam int L_D5 = 7;

    // Sequencer state encoding
    // state     | meaning
    // ST_IDLE   | waiting for start
    // ST_REQ    | pu_start high, waiting for poly_uniform done
    // ST_REL    | pu_start low, waiting for done to fall plus one settle cycle
    // ST_STREAM | serializing the captured polynomial
    // ST_FIN    | one-cycle done pulse
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_REL    = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // Row and column are independent 8-bit fields; no carry between them.
    function automatic logic [15:0] pack_nonce(input logic [7:0] row, input logic [7:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/matrix_expand_stream_if.sv
// -----------------------------------------------------------------------------
// matrix_expand_stream_if
// Coefficient stream from the matrix expander to the NTT-domain multiply stage.
//   c_valid : coefficient valid (master)
//   c_ready : downstream ready (slave)
//   c_data  : signed coefficient
//   c_row   : matrix row index i
//   c_col   : matrix column index j
//   c_idx   : coefficient index 0..255
//   c_last  : final coefficient of the whole matrix
// -----------------------------------------------------------------------------
interface matrix_expand_stream_if;

    logic        c_valid;
    logic        c_ready;
    logic [31:0] c_data;
    logic [7:0]  c_row;
    logic [7:0]  c_col;
    logic [7:0]  c_idx;
    logic        c_last;

    modport master (
        output c_valid,
        output c_data,
        output c_row,
        output c_col,
        output c_idx,
        output c_last,
        input  c_ready
    );

    modport slave (
        input  c_valid,
        input  c_data,
        input  c_row,
        input  c_col,
        input  c_idx,
        input  c_last,
        output c_ready
    );

endinterface

// File: rtl/matrix_expand_stream_coeff_serializer.sv
// -----------------------------------------------------------------------------
// coeff_serializer
// Holds one captured poly_uniform result and emits it one coefficient per
// handshake on the coefficient stream.
//   clock, reset : system clock, asynchronous active-low reset
//   capture      : load pu_a into the capture register and rewind idx
//   pu_a         : 256 x 32-bit coefficients, coefficient n at [32n+31:32n]
//   stream_en    : drives c_valid; high while the sequencer is streaming
//   row, col     : tag for the polynomial being streamed
//   final_poly   : current polynomial is the last of the matrix
//   fire         : handshake this cycle (c_valid & c_ready)
//   idx_last     : idx is at the final coefficient
//   coef         : coefficient stream (master)
// -----------------------------------------------------------------------------
module coeff_serializer
    import dilithium_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [N*32-1:0]      pu_a,
    input  logic                 stream_en,
    input  logic [7:0]           row,
    input  logic [7:0]           col,
    input  logic                 final_poly,
    output logic                 fire,
    output logic                 idx_last,
    matrix_expand_stream_if.master coef
);

    logic [N*32-1:0] buf_q;
    logic [7:0]      idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            idx   <= '0;
        end else if (capture) begin
            buf_q <= pu_a;
            idx   <= '0;
        end else if (fire) begin
            // 8-bit wrap after coefficient 255 leaves idx at 0 for the next poly
            idx <= idx + 8'd1;
        end
    end

    assign fire     = stream_en && coef.c_ready;
    assign idx_last = (idx == 8'(N - 1));

    // Everything below is a function of registered state only, so the beat
    // holds steady for as long as the consumer stalls.
    assign coef.c_valid = stream_en;
    assign coef.c_data  = buf_q[{idx, 5'b00000} +: 32];
    assign coef.c_row   = row;
    assign coef.c_col   = col;
    assign coef.c_idx   = idx;
    assign coef.c_last  = stream_en && final_poly && idx_last;

endmodule

// File: rtl/matrix_expand_stream.sv
// -----------------------------------------------------------------------------
// matrix_expand_stream
// Expands seed rho into the K x L public matrix A by driving poly_uniform once
// per (row, col) in row-major order, then streaming each 256-coefficient
// polynomial over the coefficient stream with row/col/idx tags.
//
//   clock, reset : system clock, asynchronous active-low reset
//   start, rho   : one-cycle start pulse and 256-bit matrix seed
//   busy, done   : busy from accepted start until done; done is a 1-cycle pulse
//   pu_start     : poly_uniform start (held until pu_done is seen)
//   pu_seed      : latched rho
//   pu_nonce     : {row[7:0], col[7:0]}
//   pu_done      : poly_uniform done (valid only while pu_start is high)
//   pu_a         : poly_uniform result, coefficient n at [32n+31:32n]
//   coef         : coefficient stream (master)
//   range_err    : sticky out-of-range flag, only with MATRIX_RANGE_CHECK_EN
//
// Build option: define MATRIX_RANGE_CHECK_EN to add the range_err port and the
// 0 <= c_data < Q check on every accepted coefficient.
// -----------------------------------------------------------------------------
module matrix_expand_stream
    import dilithium_pkg::*;
#(
    parameter int K = K_D2,
    parameter int L = L_D2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [255:0]         rho,
    output logic                 busy,
    output logic                 done,
    output logic                 pu_start,
    output logic [255:0]         pu_seed,
    output logic [15:0]          pu_nonce,
    input  logic                 pu_done,
    input  logic [N*32-1:0]      pu_a,
    matrix_expand_stream_if.master coef
`ifdef MATRIX_RANGE_CHECK_EN
    ,
    output logic                 range_err
`endif
);

    logic [2:0] state;
    logic [7:0] row;
    logic [7:0] col;
    logic       rel_wait;
    logic       capture;
    logic       stream_en;
    logic       final_poly;
    logic       fire;
    logic       idx_last;
    logic       last_col;
    logic       last_row;

    assign last_col   = (col == 8'(L - 1));
    assign last_row   = (row == 8'(K - 1));
    assign final_poly = last_row && last_col;
    assign capture    = (state == ST_REQ) && pu_done;
    assign stream_en  = (state == ST_STREAM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            rel_wait <= 1'b0;
            pu_seed  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pu_seed <= rho;
                        row     <= '0;
                        col     <= '0;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // poly_uniform only holds done while start is high, so
                    // the capture happens on the same edge that releases start.
                    if (pu_done) begin
                        rel_wait <= 1'b0;
                        state    <= ST_REL;
                    end
                end
                ST_REL: begin
                    // After done falls, one more cycle lets poly_uniform get
                    // back to its ready-for-start state.
                    if (pu_done) begin
                        rel_wait <= 1'b0;
                    end else if (rel_wait) begin
                        rel_wait <= 1'b0;
                        state    <= ST_STREAM;
                    end else begin
                        rel_wait <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (fire && idx_last) begin
                        if (!last_col) begin
                            col   <= col + 8'd1;
                            state <= ST_REQ;
                        end else if (!last_row) begin
                            col   <= '0;
                            row   <= row + 8'd1;
                            state <= ST_REQ;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register so an asynchronous reset
    // drops pu_start and busy without waiting for a clock.
    assign pu_start = (state == ST_REQ);
    assign busy     = (state == ST_REQ) || (state == ST_REL) || (state == ST_STREAM);
    assign done     = (state == ST_FIN);
    assign pu_nonce = pack_nonce(row, col);

    coeff_serializer u_ser (
        .clock      (clock),
        .reset      (reset),
        .capture    (capture),
        .pu_a       (pu_a),
        .stream_en  (stream_en),
        .row        (row),
        .col        (col),
        .final_poly (final_poly),
        .fire       (fire),
        .idx_last   (idx_last),
        .coef       (coef)
    );

`ifdef MATRIX_RANGE_CHECK_EN
    // Unsigned compare also rejects negative values, whose sign bit makes them
    // larger than Q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            range_err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            range_err <= 1'b0;
        end else if (fire && (coef.c_data >= 32'(Q))) begin
            range_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/matrix_expand_stream.md
Name: matrix_expand_stream

Overview:
- Sequencer directly downstream of poly_uniform; drives its start/seed/nonce and consumes the a_out bus it produces.
- Generates the full K×L public matrix A from seed rho. For each (row i, col j) it requests one polynomial with nonce = (i<<8)|j.
- Latches the 256-coefficient result and streams it one coefficient per cycle over a valid/ready interface to the NTT-domain multiply stage.
- Tags every coefficient with row, column and index.

Parameters:
- K, 4, matrix rows (Dilithium2=4, 3=6, 5=8)
- L, 4, matrix columns (Dilithium2=4, 3=5, 5=7)
- N, 256, coefficients per polynomial
- Q, 8380417, modulus (range check only)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin expansion of the whole matrix
- rho  in  256  matrix seed; sampled on the accepted start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last coefficient handshake
- pu_start  out  1  to poly_uniform.start
- pu_seed  out  256  to poly_uniform.seed (latched rho)
- pu_nonce  out  16  to poly_uniform.nonce, {row[7:0], col[7:0]}
- pu_done  in  1  from poly_uniform.done
- pu_a  in  8192  from poly_uniform.a_out; coefficient n at bits [32n+31:32n]
- c_valid  out  1  coefficient valid
- c_ready  in  1  downstream ready
- c_data  out  32  signed coefficient
- c_row  out  8  row index i
- c_col  out  8  column index j
- c_idx  out  8  coefficient index 0..255
- c_last  out  1  high on idx 255 of row K-1, col L-1
- range_err  out  1  sticky error flag; present only with the optional feature

Behaviour:
- Reset (asynchronous, reset=0): FSM to IDLE. busy, done, pu_start, c_valid and c_last = 0. Counters row/col/idx and the capture buffer = 0. range_err = 0. pu_seed = 0.
- FSM states: IDLE, REQ, REL, STREAM, FIN.
- IDLE:
  - start=1 → latch rho into pu_seed; row=col=0; busy=1; go to REQ.
  - start while not in IDLE is ignored.
- REQ:
  - pu_start=1 and pu_nonce held stable.
  - On pu_done=1: capture pu_a into the 8192-bit buffer, drop pu_start next cycle, go to REL.
  - pu_start must remain high until pu_done is seen, because poly_uniform holds done only while start is high.
- REL:
  - pu_start=0; wait for pu_done=0.
  - Then spend one extra cycle in REL so poly_uniform reaches its ready-for-start state.
  - Then go to STREAM with idx=0.
- STREAM:
  - c_valid=1; c_data = buffer[32·idx+31 : 32·idx]; c_row/c_col/c_idx reflect the counters.
  - On c_valid&c_ready: idx++.
  - idx=255 handshake with col<L-1 → col++, go to REQ.
  - idx=255 handshake with col=L-1, row<K-1 → col=0, row++, go to REQ.
  - idx=255 handshake with col=L-1, row=K-1 → go to FIN.
  - c_valid stays high and outputs stay stable while c_ready=0 (AXI-stream rules).
- FIN: done=1 for exactly one cycle; busy=0; return to IDLE. A start in that same cycle is ignored.
- Ordering: row-major (j inner), matching expand_mat.
- Nonce arithmetic: 8-bit row/col fields, no carry between them.
- Throughput: 1 coefficient/cycle with c_ready held high. The gap between polynomials is poly_uniform latency + 3 cycles.
- Reset mid-operation: immediate abort; pu_start drops asynchronously; no done pulse.

Optional Feature:
- Macro: MATRIX_RANGE_CHECK_EN.
- Defined:
  - Each coefficient accepted on the c_valid&c_ready handshake is checked for 0 ≤ c_data < Q.
  - Any violation sets range_err. It stays set until the next accepted start or reset.
  - Streaming is not stalled.
- Undefined: the range_err port and its logic are absent.

Decomposition:
- Shared package dilithium_pkg holds:
  - constants N, Q, and K/L per security level;
  - the FSM state encoding (3-bit localparams);
  - the nonce-pack function {row, col}.
- One sub-module: coeff_serializer. It holds the 8192-bit capture register, the idx counter and the valid/ready output stage.
- The sequencer FSM stays in the top.

Test Plan:
- K=L=4, rho=0, behavioural poly_uniform model returning coeff n = 1000·nonce+n, c_ready=1 → 4096 handshakes, in order (0,0,0)…(3,3,255). c_data matches the model. c_last only on the final beat. done pulses once.
- Nonce sequence check → pu_nonce values 0x0000, 0x0001, 0x0002, 0x0003, 0x0100 … 0x0303, each held for its whole REQ phase.
- Random c_ready (50%) → c_data, c_row, c_col, c_idx stable during stalls; no beat dropped or duplicated; all 4096 beats received.
- Model holds pu_done high for 5 cycles after pu_start falls → block stays in REL; next pu_start rises no earlier than 2 cycles after pu_done falls.
- Reset asserted mid-STREAM at (1,2,100) → outputs reach reset values immediately; a new start replays from (0,0,0) with the new rho.
- MATRIX_RANGE_CHECK_EN: model injects coefficient 8380417 at (2,1,7) → range_err rises on that handshake, stays high through done, and clears on the next start.
